dense_output_layer: RTL and testbench

Final fully-connected layer of the classifier. It takes the hidden-layer activation vector in Q8.8 and computes 10 logits, one sequential multiply-accumulate per cycle. Each logit is a weighted sum plus a bias, saturated back to Q8.8. The logits drive `neuron_outputs`/`in_valid` of `softmax_unit` directly downstream. Weights and biases live in an internal register file loaded through a simple write port.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/q88_mac.sv | 41 ++++
 rtl/dense_output_layer.sv | 131 +++++++++++++
 tb/tb_dense_output_layer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared Q8.8 datapath constants, FSM state encoding and the accumulator
// saturation helper used by the dense output layer.
package nn_pkg;

    localparam int DW    = 16;
    localparam int FRAC  = 8;
    localparam int ACC_W = 40;

    localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DW-1:0] SAT_NEG = 16'h8000;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -40'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Q16.16 accumulator back to Q8.8: arithmetic shift (floor), then clamp
    function automatic logic [DW-1:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> FRAC;
        if (shifted > ACC_MAX) begin
            sat16 = SAT_POS;
        end else if (shifted < ACC_MIN) begin
            sat16 = SAT_NEG;
        end else begin
            sat16 = shifted[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/q88_mac.sv
// Signed Q8.8 multiply-accumulate with a 40-bit Q16.16 accumulator.
// load preloads the bias (scaled to Q16.16), acc_en adds one x*w product,
// sat_out is the accumulator shifted back to Q8.8 and saturated.
module q88_mac
    import nn_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          acc_en,
    input  logic [DW-1:0] bias,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] w,
    output logic [DW-1:0] sat_out
);

    logic signed [ACC_W-1:0] acc;
    logic signed [2*DW-1:0]  prod;

    // Full-precision signed product, Q16.16
    always_comb begin
        prod = $signed(x) * $signed(w);
    end

    // Accumulator: bias preload, then one product per enabled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= {{(ACC_W-DW-FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
        end else if (acc_en) begin
            acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        end
    end

    // Rescaled, saturated view of the running sum
    always_comb begin
        sat_out = sat16(acc);
    end

endmodule

// File: rtl/dense_output_layer.sv
// Final fully-connected classifier layer: N_OUT logits, each a bias plus
// N_IN weighted Q8.8 activations, computed one MAC per cycle. Weights and
// biases sit in an internal register file written through a simple port
// that is only open while idle. Results are staged and published together
// so the downstream softmax sees a stable vector between pulses.
module dense_output_layer #(
    parameter int N_IN  = 32,
    parameter int N_OUT = 10,
    parameter int DW    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_IN*DW-1:0]                in_vec,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              wr_en,
    input  logic [$clog2(N_OUT*(N_IN+1))-1:0] wr_addr,
    input  logic [DW-1:0]                     wr_data,
    output logic [N_OUT*DW-1:0]               neuron_outputs,
    output logic                              out_valid
);

    import nn_pkg::*;

    localparam int NP = N_OUT * (N_IN + 1);
    localparam int AW = $clog2(NP);
    localparam int IW = $clog2(N_IN);
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t              state;
    logic [IW-1:0]       i_cnt;
    logic [JW-1:0]       j_cnt;
    logic [AW-1:0]       row_base;
    logic [N_IN*DW-1:0]  in_buf;
    logic [N_OUT*DW-1:0] res;
    logic [DW-1:0]       params [NP];

    logic [DW-1:0]       x_cur;
    logic [DW-1:0]       w_cur;
    logic [DW-1:0]       b_cur;
    logic [DW-1:0]       mac_sat;
    logic                mac_load;
    logic                mac_acc;

    // Handshake and MAC control decode straight from state
    always_comb begin
        in_ready = (state == IDLE);
        mac_load = (state == INIT);
        mac_acc  = (state == MAC);
    end

    // Operand selection: row_base tracks j*(N_IN+1), bias sits at row end
    always_comb begin
        x_cur = in_buf[int'(i_cnt)*DW +: DW];
        w_cur = params[row_base + AW'(i_cnt)];
        b_cur = params[row_base + AW'(N_IN)];
    end

    // Parameter write port, open only while idle and only for valid addresses
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE) && (32'(wr_addr) < NP)) begin
            params[wr_addr] <= wr_data;
        end
    end

    q88_mac u_mac (
        .clk     (clk),
        .rst     (rst),
        .load    (mac_load),
        .acc_en  (mac_acc),
        .bias    (b_cur),
        .x       (x_cur),
        .w       (w_cur),
        .sat_out (mac_sat)
    );

    // Sequencer: accept, per-neuron INIT/MAC/WRITE, then publish in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            i_cnt          <= '0;
            j_cnt          <= '0;
            row_base       <= '0;
            in_buf         <= '0;
            res            <= '0;
            neuron_outputs <= '0;
            out_valid      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_buf   <= in_vec;
                        j_cnt    <= '0;
                        row_base <= '0;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    i_cnt <= '0;
                    state <= MAC;
                end
                MAC: begin
                    i_cnt <= i_cnt + 1'b1;
                    if (i_cnt == IW'(N_IN - 1)) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    res[int'(j_cnt)*DW +: DW] <= mac_sat;
                    j_cnt    <= j_cnt + 1'b1;
                    row_base <= row_base + AW'(N_IN + 1);
                    if (j_cnt == JW'(N_OUT - 1)) begin
                        state <= DONE;
                    end else begin
                        state <= INIT;
                    end
                end
                DONE: begin
                    neuron_outputs <= res;
                    out_valid      <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_output_layer.sv
// Self-checking bench for dense_output_layer (N_IN=4, N_OUT=10).
// Accepted vectors push their expected logits and accept time onto a
// scoreboard; each out_valid pulse pops one entry and checks latency and
// all logits. Uniform-weight cases are table driven; routing, handshake
// and reset scenarios are hand-written sequences.
module tb_dense_output_layer;

    localparam int  N_IN   = 4;
    localparam int  N_OUT  = 10;
    localparam int  DW     = 16;
    localparam int  AW     = $clog2(N_OUT*(N_IN+1));
    localparam int  XW     = N_IN*DW;
    localparam int  VW     = N_OUT*DW;
    localparam time PERIOD = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [XW-1:0] in_vec;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [VW-1:0] neuron_outputs;
    logic          out_valid;

    dense_output_layer #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .DW    (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_vec         (in_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .neuron_outputs (neuron_outputs),
        .out_valid      (out_valid)
    );

    always #(PERIOD/2) clk = ~clk;

    typedef struct {
        logic [VW-1:0] logits;
        time           t_acc;
    } exp_t;

    typedef struct {
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] x;
        logic [15:0] logit;
    } vec_t;

    exp_t          sb[$];
    time           acc_times[$];
    logic [VW-1:0] exp_cur;
    int            checks       = 0;
    int            failures     = 0;
    int            accept_count = 0;
    int            pulse_count  = 0;

    time           mon_tp;
    exp_t          mon_e;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [XW-1:0] pack_x(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    // With weight 1.0 on input j%4 and bias j*0x10, logit j = x[j%4] + j*0x10
    function automatic logic [VW-1:0] routing_exp(input logic [XW-1:0] x);
        logic [VW-1:0] r;
        r = '0;
        for (int j = 0; j < N_OUT; j++) begin
            r[j*DW +: DW] = x[(j % N_IN)*DW +: DW] + 16'(j * 16);
        end
        return r;
    endfunction

    // Record accepts at the edge, using the pre-edge in_ready
    initial forever begin
        @(posedge clk);
        if (!rst && in_valid && in_ready) begin
            sb.push_back('{logits: exp_cur, t_acc: $time});
            acc_times.push_back($time);
            accept_count++;
        end
    end

    // Output monitor: sample just after each edge, check every pulse
    initial forever begin
        @(posedge clk);
        mon_tp = $time;
        #1;
        if (out_valid) begin
            pulse_count++;
            if (sb.size() == 0) begin
                check("unexpected_pulse", VW'(out_valid), '0);
            end else begin
                mon_e = sb.pop_front();
                check("latency", VW'(mon_tp - mon_e.t_acc), VW'(61 * PERIOD));
                for (int j = 0; j < N_OUT; j++) begin
                    check($sformatf("logit%0d", j), VW'(neuron_outputs[j*DW +: DW]),
                          VW'(mon_e.logits[j*DW +: DW]));
                end
            end
        end
    end

    task automatic write_param(input int addr, input logic [15:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load_uniform(input logic [15:0] w, input logic [15:0] b);
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                write_param(j*(N_IN+1) + i, w);
            end
            write_param(j*(N_IN+1) + N_IN, b);
        end
    endtask

    task automatic load_routing();
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                write_param(j*(N_IN+1) + i, (i == j % N_IN) ? 16'h0100 : 16'h0000);
            end
            write_param(j*(N_IN+1) + N_IN, 16'(j * 16));
        end
    endtask

    task automatic send(input logic [XW-1:0] x, input logic [VW-1:0] e);
        int n;
        int waited;
        n      = accept_count;
        waited = 0;
        @(negedge clk);
        in_vec   = x;
        exp_cur  = e;
        in_valid = 1'b1;
        while (accept_count == n && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        in_valid = 1'b0;
        check("accepted", VW'(accept_count - n), VW'(1));
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("drain", VW'(sb.size()), '0);
        sb.delete();
    endtask

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t          tbl [7];
        logic [XW-1:0] xr;
        logic [XW-1:0] xs [3];
        logic [VW-1:0] e;
        logic [VW-1:0] held;
        int            n0;
        int            k;
        int            lastp;
        int            waited;
        int            p;

        tbl[0] = '{w: 16'hFF00, b: 16'h0000, x: 16'h0080, logit: 16'hFE00};
        tbl[1] = '{w: 16'h0001, b: 16'h0000, x: 16'hFFFF, logit: 16'hFFFF};
        tbl[2] = '{w: 16'h7FFF, b: 16'h0000, x: 16'h7FFF, logit: 16'h7FFF};
        tbl[3] = '{w: 16'h8000, b: 16'h0000, x: 16'h7FFF, logit: 16'h8000};
        tbl[4] = '{w: 16'h0100, b: 16'h0100, x: 16'h0040, logit: 16'h0200};
        tbl[5] = '{w: 16'h0080, b: 16'h0080, x: 16'hFF00, logit: 16'hFE80};
        tbl[6] = '{w: 16'h0100, b: 16'h7FFF, x: 16'h0100, logit: 16'h7FFF};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_vec   = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        exp_cur  = '0;

        // Power-on reset state
        #7;
        check("reset_outputs", neuron_outputs, '0);
        check("reset_out_valid", VW'(out_valid), '0);
        check("reset_in_ready", VW'(in_ready), VW'(1));
        @(negedge clk);
        rst = 1'b0;

        // Routing: weight 1.0 on input j%4, bias j*0x10
        load_routing();
        xr = pack_x(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        send(xr, routing_exp(xr));
        drain();
        check("routing_logit0", VW'(neuron_outputs[0*DW +: DW]), VW'(16'h0100));
        check("routing_logit5", VW'(neuron_outputs[5*DW +: DW]), VW'(16'h0250));
        check("routing_logit9", VW'(neuron_outputs[9*DW +: DW]), VW'(16'h0290));

        // Write and accept on the same idle edge: new w[0][0]=2.0 is used
        e = routing_exp(xr);
        e[15:0] = 16'h0200;
        n0 = accept_count;
        @(negedge clk);
        wr_en    = 1'b1;
        wr_addr  = AW'(0);
        wr_data  = 16'h0200;
        in_vec   = xr;
        exp_cur  = e;
        in_valid = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
        in_valid = 1'b0;
        check("same_edge_accept", VW'(accept_count - n0), VW'(1));
        drain();
        write_param(0, 16'h0100);

        // Writes while busy are dropped
        send(xr, routing_exp(xr));
        repeat (10) @(negedge clk);
        write_param(0, 16'h7FFF);
        write_param(N_IN, 16'h7FFF);
        drain();
        send(xr, routing_exp(xr));
        drain();

        // in_valid held high: one accept per 62 cycles, outputs hold between pulses
        xs[0] = pack_x(16'h0010, 16'h0020, 16'h0030, 16'h0040);
        xs[1] = pack_x(16'h0500, 16'h0600, 16'h0700, 16'h0800);
        xs[2] = pack_x(16'hFF00, 16'hFE00, 16'h0100, 16'h0000);
        n0 = accept_count;
        @(negedge clk);
        in_vec   = xs[0];
        exp_cur  = routing_exp(xs[0]);
        in_valid = 1'b1;
        held     = neuron_outputs;
        lastp    = pulse_count;
        waited   = 0;
        while (accept_count - n0 < 3 && waited < 400) begin
            @(negedge clk);
            waited++;
            k = accept_count - n0;
            if (k < 3) begin
                in_vec  = xs[k];
                exp_cur = routing_exp(xs[k]);
            end
            if (pulse_count != lastp) begin
                held  = neuron_outputs;
                lastp = pulse_count;
            end else begin
                check("hold_stable", neuron_outputs, held);
            end
        end
        in_valid = 1'b0;
        check("hold_accepts", VW'(accept_count - n0), VW'(3));
        check("hold_spacing1", VW'(acc_times[$-1] - acc_times[$-2]), VW'(62 * PERIOD));
        check("hold_spacing2", VW'(acc_times[$] - acc_times[$-1]), VW'(62 * PERIOD));
        drain();

        // Reset 20 cycles into a run: no pulse, outputs cleared, weights kept
        send(xr, routing_exp(xr));
        repeat (19) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outputs", neuron_outputs, '0);
        check("midrst_out_valid", VW'(out_valid), '0);
        check("midrst_in_ready", VW'(in_ready), VW'(1));
        sb.delete();
        p = pulse_count;
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("midrst_no_pulse", VW'(pulse_count - p), '0);
        send(xr, routing_exp(xr));
        drain();

        // Uniform-weight table: sign, floor, saturation, bias handling
        for (int r = 0; r < 7; r++) begin
            load_uniform(tbl[r].w, tbl[r].b);
            send({N_IN{tbl[r].x}}, {N_OUT{tbl[r].logit}});
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
